decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I/RV64I decode stage with valid/ready handshake on both sides.
- Extracts instruction fields and classifies the format from the opcode.
- Produces a single format-selected, sign-extended immediate of XLEN bits.
- Sits between the fetch buffer and the register-read/execute stage. A 2-entry skid buffer gives full throughput under backpressure.

Parameters:
XLEN, 32, datapath width for immediate and PC; legal values 32 or 64
RVE, 0, 1 = RV32E mode: any used register index >= 16 flags illegal

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instruction  in  32  raw instruction word
in_pc  in  XLEN  instruction address, passed through
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  passed-through PC
out_opcode  out  7  instruction[6:0]
out_funct3  out  3  instruction[14:12]
out_funct7  out  7  instruction[31:25]
out_rs1  out  5  instruction[19:15]
out_rs2  out  5  instruction[24:20]
out_rd  out  5  instruction[11:7]
out_immediate  out  XLEN  selected sign-extended immediate
out_format  out  6  one-hot {J,U,B,S,I,R}, bit0 = R
out_illegal  out  1  unsupported opcode or RVE violation

Behaviour:
Reset (reset_n low, async):
- All outputs and internal registers go to 0; in_ready = 0.
- in_ready rises on the first clock edge after reset_n deasserts.

Format decode by opcode (combinational, before the register):
- 0110111 LUI -> U; 0010111 AUIPC -> U; 1101111 -> J; 1100011 -> B; 0100011 -> S; 0110011 -> R.
- 1100111, 0000011, 0010011, 0001111, 1110011 -> I.
- Any other opcode, including instruction[1:0] != 11: out_format = 0, out_illegal = 1, immediate = 0.

Immediates; every one is sign-extended from bit 31 to XLEN:
- I: instruction[31:20].
- S: {instruction[31:25], instruction[11:7]}.
- B: {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
- U: {instruction[31:12], 12'b0}, sign-extended when XLEN = 64.
- J: {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
- R format: immediate = 0.

RVE = 1:
- Illegal if any register field the format uses has bit 4 set.
- Fields used: R uses rd, rs1, rs2; I uses rd, rs1; S and B use rs1, rs2; U and J use rd.

Handshake and buffering:
- Two registers: main (drives outputs) and skid.
- Accept when in_valid & in_ready. Decode result is registered, so input-to-output latency is 1 cycle.
- in_ready = ~skid_valid, taken from a register (no combinational path from out_ready).
- Main empty, or main draining this cycle (out_valid & out_ready): an accepted entry goes to main.
- Main holding and stalled: an accepted entry goes to skid. On the next drain of main, skid moves into main and skid_valid clears.
- Output fields stay stable while out_valid = 1 and out_ready = 0.
- Throughput is one instruction per cycle while out_ready stays high.
- Entries leave strictly in arrival order; no loss, no duplication.

flush:
- Clears main and skid valids at the next edge. Payload registers may hold stale data.
- An input offered in the flush cycle is dropped.
- in_ready is 1 in the cycle after a flush.

Simultaneous events:
- Accept and drain in the same cycle with main full and skid empty: new entry replaces main.
- Skid full: in_ready = 0 until main drains.
- Reset mid-operation: all entries are lost and outputs go to 0 immediately (async).

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready = 1 -> one cycle later out_valid = 1, out_format = 000010, rd = 1, rs1 = 0, out_immediate = 0xFFFFFFFF (XLEN 32) or all ones (XLEN 64), out_illegal = 0.
- sw x2,-4(x3) (0xFE21AE23) -> S format (000100), rs1 = 3, rs2 = 2, funct3 = 010, out_immediate = 0xFFFFFFFC.
- lui x5,0x12345 (0x123452B7) -> U format (010000), rd = 5, out_immediate = 0x12345000; beq x0,x0,-8 (0xFE000CE3) -> B format, out_immediate = 0xFFFFFFF8.
- in_instruction = 0x00000000, then 0xFFFFFFFF -> out_illegal = 1, out_format = 0, out_immediate = 0. With RVE = 1, add x16,x1,x2 (0x00208833) -> out_illegal = 1.
- Stream of 8 instructions, out_ready held low after the first accept -> in_ready drops after 2 accepts. Release out_ready -> all 8 emerge in order, no gaps once out_ready stays high, outputs stable while stalled.
- Pulse flush with both entries full -> out_valid = 0 next cycle, in_ready = 1. Assert reset_n = 0 mid-stream -> outputs go to 0 asynchronously and nothing is emitted afterward.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: field extraction, format classification and immediate
// generation, registered behind a valid/ready handshake with a 2-entry skid buffer.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit RVE  = 1'b0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_immediate,
  output logic [5:0]      out_format,
  output logic            out_illegal
);

  localparam logic [5:0] FMT_R    = 6'b000001;
  localparam logic [5:0] FMT_I    = 6'b000010;
  localparam logic [5:0] FMT_S    = 6'b000100;
  localparam logic [5:0] FMT_B    = 6'b001000;
  localparam logic [5:0] FMT_U    = 6'b010000;
  localparam logic [5:0] FMT_J    = 6'b100000;
  localparam logic [5:0] FMT_NONE = 6'b000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [5:0]      fmt;
    logic            illegal;
  } entry_t;

  function automatic logic [5:0] format_of(input logic [6:0] opcode);
    logic [5:0] fmt;
    case (opcode)
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b1100011:             fmt = FMT_B;
      7'b0100011:             fmt = FMT_S;
      7'b0110011:             fmt = FMT_R;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: fmt = FMT_I;
      default:                fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN+31:0] wide;
    wide = {{XLEN{v[31]}}, v};
    return wide[XLEN-1:0];
  endfunction

  // All immediates are first formed as 32-bit sign-extended values, then widened.
  function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins, input logic [5:0] fmt);
    logic [31:0] raw;
    case (fmt)
      FMT_I:   raw = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   raw = {ins[31:12], 12'h000};
      FMT_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: raw = 32'h0000_0000;
    endcase
    return sext32(raw);
  endfunction

  function automatic logic rve_violation(input logic [31:0] ins, input logic [5:0] fmt);
    logic bad;
    case (fmt)
      FMT_R:        bad = ins[11] | ins[19] | ins[24];
      FMT_I:        bad = ins[11] | ins[19];
      FMT_S, FMT_B: bad = ins[19] | ins[24];
      FMT_U, FMT_J: bad = ins[11];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  entry_t     dec_s;
  entry_t     main_r;
  entry_t     skid_r;
  logic [5:0] dec_fmt_s;
  logic       main_valid_r;
  logic       skid_valid_r;
  logic       ready_r;
  logic       main_valid_s;
  logic       skid_valid_s;
  logic       accept_s;
  logic       main_free_s;
  logic       load_main_dec_s;
  logic       load_main_skid_s;
  logic       load_skid_s;

  // Decode the incoming instruction into a buffer entry.
  always_comb begin
    dec_fmt_s     = format_of(in_instruction[6:0]);
    dec_s         = '0;
    dec_s.pc      = in_pc;
    dec_s.instr   = in_instruction;
    dec_s.fmt     = dec_fmt_s;
    dec_s.imm     = imm_of(in_instruction, dec_fmt_s);
    if (RVE) begin
      dec_s.illegal = (dec_fmt_s == FMT_NONE) | rve_violation(in_instruction, dec_fmt_s);
    end else begin
      dec_s.illegal = (dec_fmt_s == FMT_NONE);
    end
  end

  assign accept_s    = in_valid & ready_r & ~flush;
  assign main_free_s = ~main_valid_r | out_ready;

  // Buffer steering: skid refills main first; otherwise a new entry lands in main or skid.
  always_comb begin
    main_valid_s     = main_valid_r;
    skid_valid_s     = skid_valid_r;
    load_main_dec_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_valid_s     = 1'b1;
        skid_valid_s     = 1'b0;
        load_main_skid_s = 1'b1;
      end else if (accept_s) begin
        main_valid_s    = 1'b1;
        load_main_dec_s = 1'b1;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_s = 1'b1;
        load_skid_s  = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Valid flags and registered in_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      ready_r      <= ~skid_valid_s;
    end
  end

  // Payload registers; they keep their contents when not loaded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_skid_s) begin
        main_r <= skid_r;
      end else if (load_main_dec_s) begin
        main_r <= dec_s;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready      = ready_r;
  assign out_valid     = main_valid_r;
  assign out_pc        = main_r.pc;
  assign out_opcode    = main_r.instr[6:0];
  assign out_funct3    = main_r.instr[14:12];
  assign out_funct7    = main_r.instr[31:25];
  assign out_rs1       = main_r.instr[19:15];
  assign out_rs2       = main_r.instr[24:20];
  assign out_rd        = main_r.instr[11:7];
  assign out_immediate = main_r.imm;
  assign out_format    = main_r.fmt;
  assign out_illegal   = main_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 instance and an RV64/RVE instance share stimulus.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_instruction, in_pc;
  logic [63:0] in_pc_e;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_immediate;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [5:0]  out_format;

  logic        in_ready_e, out_valid_e, out_illegal_e;
  logic [63:0] out_pc_e, out_immediate_e;
  logic [6:0]  out_opcode_e, out_funct7_e;
  logic [2:0]  out_funct3_e;
  logic [4:0]  out_rs1_e, out_rs2_e, out_rd_e;
  logic [5:0]  out_format_e;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;
  assign in_pc_e = {32'h0, in_pc};

  decode_stage #(.XLEN(32), .RVE(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_immediate(out_immediate), .out_format(out_format),
    .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(64), .RVE(1'b1)) dut_e (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_e), .in_instruction(in_instruction), .in_pc(in_pc_e),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_pc(out_pc_e), .out_opcode(out_opcode_e),
    .out_funct3(out_funct3_e), .out_funct7(out_funct7_e), .out_rs1(out_rs1_e), .out_rs2(out_rs2_e),
    .out_rd(out_rd_e), .out_immediate(out_immediate_e), .out_format(out_format_e),
    .out_illegal(out_illegal_e)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_instruction = instr;
    in_pc          = pc;
    in_valid       = 1'b1;
    tick();
    in_valid       = 1'b0;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
  endfunction

  int          sent, recv, gaps, seen;
  logic        acc, drn, started;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instruction = 32'h0; in_pc = 32'h0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_imm", 64'(out_immediate), 64'd0);
    check("rst_format", 64'(out_format), 64'd0);
    #10 reset_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(in_ready), 64'd0);
    tick();
    check("ready_after_edge", 64'(in_ready), 64'd1);

    // addi x1,x0,-1
    send(32'hFFF00093, 32'h0000_0100);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_fmt", 64'(out_format), 64'h02);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd0);
    check("addi_imm", 64'(out_immediate), 64'hFFFF_FFFF);
    check("addi_ill", 64'(out_illegal), 64'd0);
    check("addi_pc", 64'(out_pc), 64'h100);
    check("addi_opc", 64'(out_opcode), 64'h13);
    check("addi_imm64", out_immediate_e, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_pc64", out_pc_e, 64'h100);

    // sw x2,-4(x3)
    send(32'hFE21AE23, 32'h0000_0104);
    check("sw_fmt", 64'(out_format), 64'h04);
    check("sw_rs1", 64'(out_rs1), 64'd3);
    check("sw_rs2", 64'(out_rs2), 64'd2);
    check("sw_f3", 64'(out_funct3), 64'd2);
    check("sw_f7", 64'(out_funct7), 64'h7F);
    check("sw_imm", 64'(out_immediate), 64'hFFFF_FFFC);
    check("sw_imm64", out_immediate_e, 64'hFFFF_FFFF_FFFF_FFFC);
    check("sw_rve_rd_unused", 64'(out_illegal_e), 64'd0);

    // lui x5,0x12345
    send(32'h123452B7, 32'h0000_0108);
    check("lui_fmt", 64'(out_format), 64'h10);
    check("lui_rd", 64'(out_rd), 64'd5);
    check("lui_imm", 64'(out_immediate), 64'h1234_5000);
    check("lui_imm64", out_immediate_e, 64'h0000_0000_1234_5000);

    // beq x0,x0,-8
    send(32'hFE000CE3, 32'h0000_010C);
    check("beq_fmt", 64'(out_format), 64'h08);
    check("beq_imm", 64'(out_immediate), 64'hFFFF_FFF8);

    // jal x1,8
    send(32'h008000EF, 32'h0000_0110);
    check("jal_fmt", 64'(out_format), 64'h20);
    check("jal_rd", 64'(out_rd), 64'd1);
    check("jal_imm", 64'(out_immediate), 64'h8);

    // add x3,x1,x2
    send(32'h002081B3, 32'h0000_0114);
    check("add_fmt", 64'(out_format), 64'h01);
    check("add_rd", 64'(out_rd), 64'd3);
    check("add_imm", 64'(out_immediate), 64'd0);
    check("add_ill", 64'(out_illegal), 64'd0);

    send(32'h00000000, 32'h0000_0118);
    check("zero_ill", 64'(out_illegal), 64'd1);
    check("zero_fmt", 64'(out_format), 64'd0);
    check("zero_imm", 64'(out_immediate), 64'd0);
    send(32'hFFFFFFFF, 32'h0000_011C);
    check("ones_ill", 64'(out_illegal), 64'd1);
    check("ones_fmt", 64'(out_format), 64'd0);
    check("ones_imm", 64'(out_immediate), 64'd0);
    check("ones_imm64", out_immediate_e, 64'd0);

    // add x16,x1,x2: only the RVE instance flags it
    send(32'h00208833, 32'h0000_0120);
    check("x16_rv32_ill", 64'(out_illegal), 64'd0);
    check("x16_rve_ill", 64'(out_illegal_e), 64'd1);
    check("x16_rve_fmt", 64'(out_format_e), 64'h01);
    tick();
    check("drained_idle", 64'(out_valid), 64'd0);

    // Stream of 8 under backpressure, then released
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = addi_k(1);
    sent = 0; recv = 0; gaps = 0; started = 1'b0;
    for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
      if (cyc == 6) begin
        check("stall_ready", 64'(in_ready), 64'd0);
        check("stall_accepts", 64'(sent), 64'd2);
        check("stall_imm_a", 64'(out_immediate), 64'd1);
      end
      if (cyc == 9) begin
        check("stall_imm_b", 64'(out_immediate), 64'd1);
        check("stall_rd", 64'(out_rd), 64'd1);
        check("stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        check("order_rd", 64'(out_rd), 64'(recv + 1));
        recv++;
        started = 1'b1;
      end else if (started && out_ready) begin
        gaps++;
      end
      tick();
      if (acc) sent++;
      if (sent < 8) in_instruction = addi_k(sent + 1);
      else in_valid = 1'b0;
    end
    check("stream_count", 64'(recv), 64'd8);
    check("stream_gaps", 64'(gaps), 64'd0);
    check("stream_sent", 64'(sent), 64'd8);

    // Flush with both entries full
    tick();
    out_ready = 1'b0;
    send(addi_k(9), 32'h200);
    send(addi_k(10), 32'h204);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_rd", 64'(out_rd), 64'd9);
    flush = 1'b1; in_valid = 1'b1; in_instruction = addi_k(11);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    // Input offered alongside flush with in_ready high is dropped
    flush = 1'b1; in_valid = 1'b1; in_instruction = addi_k(11);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_drop_valid", 64'(out_valid), 64'd0);
    tick();
    check("flush_drop_later", 64'(out_valid), 64'd0);
    send(addi_k(12), 32'h208);
    check("post_flush_rd", 64'(out_rd), 64'd12);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_instruction = addi_k(13);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    check("arst_imm", 64'(out_immediate), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd0);
    check("arst_pc64", out_pc_e, 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    #10 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid || out_valid_e) seen++;
    end
    check("post_reset_silent", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
